// File: rtl/pq_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pq_op_scheduler
// Description : Round-robin front end for the hybrid_tree max-priority queue.
//               Grants one client request at a time. It classifies each
//               request as legal or illegal against the tracked occupancy.
//               For a legal request it issues a single-cycle queue command,
//               then holds off for a fixed settle gap, because the queue has
//               no busy indication. An ack, the popped root or an error is
//               returned to the owning client, tagged with that client's ID.
// Ports       : CLK, RSTn           clock, asynchronous active-low reset
//               i_req_valid/op/data per-client request (op 0=enq,1=deq,2=rep)
//               o_req_ready         one-hot grant (IDLE only)
//               o_rsp_*             one-cycle response pulse with id/data/err
//               o_pq_wrt/read/data  command to the queue
//               i_pq_data           current queue root
//               o_count, o_busy     tracked occupancy, not-idle flag
// Revision    : 1.0 - initial release
// ============================================================================
module pq_op_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int QUEUE_SIZE = 12,
    parameter int OP_GAP     = 24
) (
    input  logic                               CLK,
    input  logic                               RSTn,
    input  logic [NUM_REQ-1:0]                 i_req_valid,
    input  logic [2*NUM_REQ-1:0]               i_req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      i_req_data,
    output logic [NUM_REQ-1:0]                 o_req_ready,
    output logic                               o_rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]         o_rsp_id,
    output logic [DATA_WIDTH-1:0]              o_rsp_data,
    output logic                               o_rsp_err,
    output logic                               o_pq_wrt,
    output logic                               o_pq_read,
    output logic [DATA_WIDTH-1:0]              o_pq_data,
    input  logic [DATA_WIDTH-1:0]              i_pq_data,
    output logic [$clog2(QUEUE_SIZE+1)-1:0]    o_count,
    output logic                               o_busy
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(QUEUE_SIZE+1);
    localparam int c_GAP_W = (OP_GAP > 1) ? $clog2(OP_GAP) : 1;

    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(QUEUE_SIZE);

    localparam logic [1:0] c_OP_ENQ = 2'd0;
    localparam logic [1:0] c_OP_DEQ = 2'd1;
    localparam logic [1:0] c_OP_REP = 2'd2;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    logic [1:0]            r_state;
    logic [c_ID_W-1:0]     r_rr_ptr;
    logic [1:0]            r_op;
    logic [c_ID_W-1:0]     r_id;
    logic [DATA_WIDTH-1:0] r_key;
    logic [c_GAP_W-1:0]    r_gap;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_rsp_valid;
    logic [c_ID_W-1:0]     r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    logic [1:0]            w_op_arr   [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];
    logic                  w_found;
    logic [c_ID_W-1:0]     w_win;
    logic [c_ID_W-1:0]     w_scan;
    logic [NUM_REQ-1:0]    w_onehot;
    logic [1:0]            w_op;
    logic                  w_legal;
    logic                  w_accept;

    // Per-client views of the packed opcode/key buses.
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_op_arr[g]   = i_req_op[2*g +: 2];
            assign w_data_arr[g] = i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search: first valid client at or after the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_scan   = '0;
        w_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = c_ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && i_req_valid[w_scan]) begin
                w_found = 1'b1;
                w_win   = w_scan;
            end
        end
        if (w_found) begin
            w_onehot[w_win] = 1'b1;
        end
    end

    assign w_op = w_op_arr[w_win];

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            c_OP_ENQ: w_legal = (r_count != c_FULL);
            c_OP_DEQ,
            c_OP_REP: w_legal = (r_count != '0);
            default:  w_legal = 1'b0;
        endcase
    end

    // Grants are suppressed while reset is asserted so every output reads 0.
    assign o_req_ready = ((r_state == c_ST_IDLE) && RSTn) ? w_onehot : '0;
    assign w_accept    = (r_state == c_ST_IDLE) && w_found;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state     <= c_ST_IDLE;
            r_rr_ptr    <= '0;
            r_op        <= c_OP_ENQ;
            r_id        <= '0;
            r_key       <= '0;
            r_gap       <= '0;
            r_count     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_rr_ptr <= (w_win == c_ID_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
                        if (w_legal) begin
                            r_op    <= w_op;
                            r_id    <= w_win;
                            r_key   <= w_data_arr[w_win];
                            r_state <= c_ST_ISSUE;
                        end else begin
                            // Rejected without touching the queue; IDLE keeps granting.
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_id    <= w_win;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    // The root is sampled before the queue applies this command.
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_rsp_data  <= (r_op == c_OP_ENQ) ? '0 : i_pq_data;
                    if (r_op == c_OP_ENQ) begin
                        r_count <= r_count + 1'b1;
                    end else if (r_op == c_OP_DEQ) begin
                        r_count <= r_count - 1'b1;
                    end
                    r_gap   <= c_GAP_W'(OP_GAP-1);
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // Leaving as the counter reaches 0 lets the IDLE grant cycle
                    // count as the last gap cycle: commands land OP_GAP+1 apart.
                    if (r_gap <= c_GAP_W'(1)) begin
                        r_state <= c_ST_IDLE;
                    end
                    if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_pq_wrt    = (r_state == c_ST_ISSUE) && (r_op != c_OP_DEQ);
    assign o_pq_read   = (r_state == c_ST_ISSUE) && (r_op != c_OP_ENQ);
    assign o_pq_data   = (r_state == c_ST_ISSUE) ? r_key : '0;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;
    assign o_count     = r_count;
    assign o_busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pq_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pq_op_scheduler
// Description : Directed bench for pq_op_scheduler. A behavioural max-queue
//               stands in for hybrid_tree. Expected responses are queued as
//               requests are driven and are matched as responses appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pq_op_scheduler;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic [3:0]  i_req_valid;
    logic [7:0]  i_req_op;
    logic [63:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic        o_rsp_valid;
    logic [1:0]  o_rsp_id;
    logic [15:0] o_rsp_data;
    logic        o_rsp_err;
    logic        o_pq_wrt;
    logic        o_pq_read;
    logic [15:0] o_pq_data;
    logic [15:0] i_pq_data;
    logic [3:0]  o_count;
    logic        o_busy;

    always #5 CLK = ~CLK;

    pq_op_scheduler #(
        .NUM_REQ(4), .DATA_WIDTH(16), .QUEUE_SIZE(12), .OP_GAP(24)
    ) u_dut (
        .CLK(CLK), .RSTn(RSTn),
        .i_req_valid(i_req_valid), .i_req_op(i_req_op), .i_req_data(i_req_data),
        .o_req_ready(o_req_ready),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
        .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
        .i_pq_data(i_pq_data), .o_count(o_count), .o_busy(o_busy)
    );

    // Behavioural max-queue kept sorted in descending order; slot 0 is the root.
    logic [15:0] pq_mem [0:15];
    int          pq_n;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pq_n <= 0;
            for (int i = 0; i < 16; i++) pq_mem[i] <= '0;
        end else if (o_pq_wrt || o_pq_read) begin
            logic [15:0] t [0:15];
            int n;
            int p;
            for (int i = 0; i < 16; i++) t[i] = pq_mem[i];
            n = pq_n;
            if (o_pq_read && n > 0) begin
                for (int i = 0; i < 15; i++) t[i] = t[i+1];
                t[15] = '0;
                n = n - 1;
            end
            if (o_pq_wrt && n < 16) begin
                p = n;
                while (p > 0 && t[p-1] < o_pq_data) begin
                    t[p] = t[p-1];
                    p = p - 1;
                end
                t[p] = o_pq_data;
                n = n + 1;
            end
            for (int i = 0; i < 16; i++) pq_mem[i] <= t[i];
            pq_n <= n;
        end
    end

    assign i_pq_data = pq_mem[0];

    typedef struct {
        logic [1:0]  id;
        logic        err;
        logic [15:0] data;
    } exp_t;

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [3:0]  last_acc = '0;
    int          grant_log [$];
    int          cmd_cyc [$];
    logic [1:0]  cmd_kind [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: note accepts just before the edge, then inspect outputs after it.
    task automatic tick();
        exp_t e;
        @(negedge CLK);
        last_acc = o_req_ready & i_req_valid;
        for (int i = 0; i < 4; i++) if (last_acc[i]) grant_log.push_back(i);
        @(posedge CLK);
        #1;
        cyc++;
        if (o_pq_wrt || o_pq_read) begin
            cmd_cyc.push_back(cyc);
            cmd_kind.push_back({o_pq_wrt, o_pq_read});
        end
        if (o_rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp observed id=%0d data=%0d expected no response",
                         o_rsp_id, o_rsp_data);
            end else begin
                e = sb.pop_front();
                chk("rsp_id",   32'(o_rsp_id),   32'(e.id));
                chk("rsp_err",  32'(o_rsp_err),  32'(e.err));
                chk("rsp_data", 32'(o_rsp_data), 32'(e.data));
            end
        end
    endtask

    task automatic do_req(input int id, input logic [1:0] op, input logic [15:0] data,
                          input logic err, input logic [15:0] exp_data);
        exp_t e;
        int   t;
        bit   got;
        e.id   = 2'(id);
        e.err  = err;
        e.data = exp_data;
        sb.push_back(e);
        i_req_op[2*id +: 2]    = op;
        i_req_data[16*id +: 16] = data;
        i_req_valid[id]        = 1'b1;
        t   = 0;
        got = 1'b0;
        while (!got && t < 200) begin
            tick();
            t++;
            got = last_acc[id];
        end
        i_req_valid[id] = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout client=%0d observed=no grant expected=grant", id);
            return;
        end
        if (err) begin
            chk("lat_err_rsp", 32'(o_rsp_valid), 32'd1);
        end else begin
            chk("issue_cmd", 32'(o_pq_wrt | o_pq_read), 32'd1);
            if (op != 2'd1) chk("pq_data", 32'(o_pq_data), 32'(data));
            tick();
            chk("lat_ok_rsp", 32'(o_rsp_valid), 32'd1);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((o_busy || sb.size() != 0) && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout observed busy=%0d pending=%0d expected idle", o_busy, sb.size());
        end
    endtask

    task automatic push_exp(input int id, input logic err, input logic [15:0] data);
        exp_t e;
        e.id   = 2'(id);
        e.err  = err;
        e.data = data;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_cmd;
        int n1;
        int t;
        RSTn        = 1'b0;
        i_req_valid = '0;
        i_req_op    = '0;
        i_req_data  = '0;
        #2;
        // Reset state
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        chk("rst_ctrl", 32'({o_rsp_valid, o_rsp_err, o_pq_wrt, o_pq_read, o_busy}), 32'd0);
        chk("rst_data", 32'({o_rsp_id, o_rsp_data, o_pq_data}), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        tick();
        tick();
        RSTn = 1'b1;

        // Back-to-back enqueues from client 0
        do_req(0, 2'd0, 16'd100, 1'b0, 16'd0);
        do_req(0, 2'd0, 16'd700, 1'b0, 16'd0);
        do_req(0, 2'd0, 16'd300, 1'b0, 16'd0);
        drain();
        chk("enq_count", 32'(o_count), 32'd3);
        chk("enq_cmds", 32'(cmd_cyc.size()), 32'd3);
        chk("enq_gap1", 32'(cmd_cyc[1] - cmd_cyc[0]), 32'd25);
        chk("enq_gap2", 32'(cmd_cyc[2] - cmd_cyc[1]), 32'd25);
        chk("enq_kind", 32'({cmd_kind[0], cmd_kind[1], cmd_kind[2]}), 32'b101010);

        // Fourth key from client 3 leaves the pointer at 0
        do_req(3, 2'd0, 16'd900, 1'b0, 16'd0);
        drain();
        chk("load4_count", 32'(o_count), 32'd4);

        // All four clients dequeue together
        grant_log.delete();
        push_exp(0, 1'b0, 16'd900);
        push_exp(1, 1'b0, 16'd700);
        push_exp(2, 1'b0, 16'd300);
        push_exp(3, 1'b0, 16'd100);
        i_req_op    = 8'b01_01_01_01;
        i_req_valid = 4'hF;
        t = 0;
        while (i_req_valid != 4'h0 && t < 300) begin
            tick();
            i_req_valid = i_req_valid & ~last_acc;
            t++;
        end
        i_req_valid = '0;
        drain();
        chk("deq_order", 32'({4'(grant_log[0]), 4'(grant_log[1]), 4'(grant_log[2]), 4'(grant_log[3])}),
            32'h0123);
        chk("deq_count", 32'(o_count), 32'd0);

        // Dequeue from an empty queue is rejected without a queue command
        n_cmd = cmd_cyc.size();
        do_req(1, 2'd1, 16'd0, 1'b1, 16'd0);
        tick();
        tick();
        chk("empty_no_cmd", 32'(cmd_cyc.size()), 32'(n_cmd));
        chk("empty_count", 32'(o_count), 32'd0);

        // Fill to capacity, overflow, replace at full, then pop the new max
        for (int i = 0; i < 12; i++) do_req(0, 2'd0, 16'(50 + 10*i), 1'b0, 16'd0);
        drain();
        chk("full_count", 32'(o_count), 32'd12);
        n_cmd = cmd_cyc.size();
        do_req(0, 2'd0, 16'd5, 1'b1, 16'd0);
        chk("ovf_no_cmd", 32'(cmd_cyc.size()), 32'(n_cmd));
        do_req(2, 2'd2, 16'd1000, 1'b0, 16'd160);
        chk("rep_kind", 32'(cmd_kind[cmd_kind.size()-1]), 32'b11);
        drain();
        chk("rep_count", 32'(o_count), 32'd12);
        do_req(0, 2'd1, 16'd0, 1'b0, 16'd1000);
        drain();
        chk("post_rep_count", 32'(o_count), 32'd11);

        // Fairness: client 1 holds valid, clients 2 and 3 ask once
        grant_log.delete();
        push_exp(1, 1'b0, 16'd150);
        push_exp(2, 1'b0, 16'd140);
        push_exp(3, 1'b0, 16'd130);
        push_exp(1, 1'b0, 16'd120);
        i_req_op    = 8'b01_01_01_01;
        i_req_valid = 4'b1110;
        n1 = 0;
        t  = 0;
        while (i_req_valid != 4'h0 && t < 400) begin
            tick();
            if (last_acc[1]) n1++;
            if (last_acc[2]) i_req_valid[2] = 1'b0;
            if (last_acc[3]) i_req_valid[3] = 1'b0;
            if (n1 >= 2) i_req_valid[1] = 1'b0;
            t++;
        end
        i_req_valid = '0;
        drain();
        chk("rr_order", 32'({4'(grant_log[0]), 4'(grant_log[1]), 4'(grant_log[2]), 4'(grant_log[3])}),
            32'h1231);
        chk("rr_count", 32'(o_count), 32'd7);

        // Reset while waiting out the gap after a dequeue
        do_req(0, 2'd1, 16'd0, 1'b0, 16'd110);
        tick();
        tick();
        tick();
        chk("wait_busy", 32'(o_busy), 32'd1);
        #2;
        RSTn = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({o_rsp_valid, o_rsp_err, o_pq_wrt, o_pq_read, o_busy}), 32'd0);
        chk("mid_rst_count", 32'(o_count), 32'd0);
        chk("mid_rst_ready", 32'(o_req_ready), 32'd0);
        tick();
        tick();
        tick();
        i_req_op[7:6]     = 2'd0;
        i_req_data[63:48] = 16'd42;
        i_req_valid[3]    = 1'b1;
        RSTn = 1'b1;
        #1;
        chk("post_rst_grant", 32'(o_req_ready), 32'b1000);
        do_req(3, 2'd0, 16'd42, 1'b0, 16'd0);
        drain();
        chk("post_rst_count", 32'(o_count), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
